// File: rtl/i2c_master_byte.sv
// Byte-level I2C master: one command per handshake (optional START, 8-bit write or read plus ACK,
// optional STOP), with slave clock stretching and arbitration-loss detection on open-drain SCL/SDA.
module i2c_master_byte #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_read,
    input  logic       cmd_ack,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       rsp_arb_lost,
    output logic       busy,
    input  logic       scl_i,
    output logic       scl_oe,
    input  logic       sda_i,
    output logic       sda_oe
);
    typedef enum logic [2:0] {IDLE, HOLD, START, BIT, STOP, RESP} state_t;

    localparam logic [15:0] TC = 16'(CLK_DIV - 1);

    state_t      state, state_n;
    logic [15:0] cnt;
    logic [1:0]  q;
    logic [3:0]  bitn;
    logic [7:0]  sh;
    logic        sbit, stop_l, read_l, ack_l, from_hold, keep;
    logic        hs, tick, stall, sample, mdrive, mval, arb;

    assign hs     = cmd_valid && cmd_ready;
    assign tick   = (cnt == TC);
    assign stall  = !scl_i && (((state == BIT) && (q == 2'd2)) || ((state == STOP) && (q == 2'd1)));
    assign sample = (state == BIT) && (q == 2'd3) && (cnt == '0);

    // bitn[3] marks the ACK slot; mval is the level the master wants on SDA (1 = released)
    assign mdrive = bitn[3] ? read_l : !read_l;
    assign mval   = bitn[3] ? (read_l ? ack_l : 1'b1) : (read_l ? 1'b1 : sh[7]);
    assign arb    = sample && mdrive && mval && !sda_i;

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE) && !((state == RESP) && rsp_arb_lost);

    always_comb begin
        state_n   = state;
        cmd_ready = 1'b0;
        scl_oe    = 1'b0;
        sda_oe    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !rst;
                if (hs) state_n = START;
            end
            HOLD: begin
                cmd_ready = !rst;
                scl_oe    = 1'b1;
                if (hs) state_n = cmd_start ? START : BIT;
            end
            START: begin
                case (q)
                    2'd0:    scl_oe = from_hold;
                    2'd1:    scl_oe = 1'b0;
                    2'd2:    sda_oe = 1'b1;
                    default: begin
                        scl_oe = 1'b1;
                        sda_oe = 1'b1;
                    end
                endcase
                if (tick && (q == 2'd3)) state_n = BIT;
            end
            BIT: begin
                scl_oe = !q[1];
                sda_oe = !mval;
                if (arb)
                    state_n = RESP;
                else if (tick && (q == 2'd3) && bitn[3])
                    state_n = stop_l ? STOP : RESP;
            end
            STOP: begin
                scl_oe = (q == 2'd0);
                sda_oe = (q != 2'd3);
                if (tick && (q == 2'd3)) state_n = RESP;
            end
            RESP: begin
                scl_oe  = keep;
                state_n = keep ? HOLD : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            q            <= '0;
            bitn         <= '0;
            sh           <= '0;
            sbit         <= 1'b0;
            stop_l       <= 1'b0;
            read_l       <= 1'b0;
            ack_l        <= 1'b0;
            from_hold    <= 1'b0;
            keep         <= 1'b0;
            rsp_rdata    <= '0;
            rsp_nack     <= 1'b0;
            rsp_arb_lost <= 1'b0;
        end else begin
            if (state_n != state) begin
                cnt <= '0;
                q   <= '0;
            end else if (!stall && (state inside {START, BIT, STOP})) begin
                if (tick) begin
                    cnt <= '0;
                    q   <= q + 2'd1;
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end

            if (state != BIT)
                bitn <= '0;
            else if (tick && (q == 2'd3))
                bitn <= bitn + 4'd1;

            if (hs) begin
                stop_l    <= cmd_stop;
                read_l    <= cmd_read;
                ack_l     <= cmd_ack;
                from_hold <= (state == HOLD);
                sh        <= cmd_wdata;
            end

            // Sampled bit is shifted in only at the end of the bit so SDA never moves while SCL is high
            if (sample) sbit <= sda_i;
            if ((state == BIT) && tick && (q == 2'd3) && !bitn[3])
                sh <= {sh[6:0], sbit};

            if ((state != RESP) && (state_n == RESP)) begin
                rsp_arb_lost <= arb;
                keep         <= !stop_l && !arb;
                rsp_rdata    <= (read_l && !arb) ? sh : '0;
                rsp_nack     <= arb ? 1'b0 : (read_l ? ack_l : sbit);
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: bus-level slave model on resolved SCL/SDA plus a response scoreboard.
module tb_i2c_master_byte;
    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_start = 1'b0, cmd_stop = 1'b0, cmd_read = 1'b0, cmd_ack = 1'b0;
    logic [7:0] cmd_wdata = '0;
    logic       cmd_ready, rsp_valid, rsp_nack, rsp_arb_lost, busy;
    logic [7:0] rsp_rdata;
    logic       scl_i, scl_oe, sda_i, sda_oe;

    logic       slv_scl_low = 1'b0, slv_sda_low = 1'b0, force_sda_low = 1'b0;
    logic       slv_read = 1'b0, slv_ack = 1'b1, arb_arm = 1'b0, stretch_arm = 1'b0, stretch_done = 1'b0;
    logic [7:0] slv_tx = '0, rxb = '0, wbyte = '0;
    logic       ps = 1'b1, psda = 1'b1, trig, rise, fall;
    int         bitcnt = 0, stretch_left = 0, stop_cnt = 0, start_cnt = 0;
    int         total = 0, bad = 0, cyc = 0, rsp_cnt = 0;

    typedef struct {
        logic [7:0] rdata;
        logic       nack;
        logic       arb;
        int         lat;
        int         hs;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    assign scl_i = ~(scl_oe | slv_scl_low);
    assign sda_i = ~(sda_oe | slv_sda_low | force_sda_low);

    i2c_master_byte #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .cmd_read(cmd_read), .cmd_ack(cmd_ack), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .rsp_arb_lost(rsp_arb_lost),
        .busy(busy), .scl_i(scl_i), .scl_oe(scl_oe), .sda_i(sda_i), .sda_oe(sda_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: START/STOP detection, bit capture on SCL rise, SDA drive after SCL fall
    always @(negedge clk) begin
        trig = 1'b0;
        if (!stretch_arm) stretch_done = 1'b0;
        if (slv_scl_low) begin
            stretch_left = stretch_left - 1;
            if (stretch_left == 0) slv_scl_low = 1'b0;
        end else if (stretch_arm && !stretch_done && bitcnt == 3 && !ps && !scl_oe) begin
            slv_scl_low  = 1'b1;
            stretch_left = 50;
            stretch_done = 1'b1;
            trig         = 1'b1;
        end
        if (!trig) begin
            rise = scl_i && !ps;
            fall = !scl_i && ps;
            if (ps && scl_i && psda && !sda_i) begin
                bitcnt = 0;
                rxb    = '0;
                start_cnt++;
            end else if (ps && scl_i && !psda && sda_i) begin
                stop_cnt++;
            end
            if (rise) begin
                if (bitcnt < 8) begin
                    rxb = {rxb[6:0], sda_i};
                    if (bitcnt == 7) wbyte = rxb;
                end
                if (arb_arm && bitcnt == 1) force_sda_low = 1'b1;
                bitcnt++;
            end
            if (fall) begin
                slv_sda_low = 1'b0;
                if (slv_read && bitcnt < 8) slv_sda_low = ~slv_tx[7 - bitcnt];
                else if (!slv_read && bitcnt == 8) slv_sda_low = slv_ack;
                if (bitcnt >= 9) bitcnt = 0;
            end
            ps   = scl_i;
            psda = sda_i;
        end else begin
            ps = 1'b0;
        end
        if (!arb_arm) force_sda_low = 1'b0;
    end

    // Scoreboard: every response is matched against the oldest expectation
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            rsp_cnt++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected got rsp_valid=1 want 0");
            end else begin
                e = sb.pop_front();
                if (rsp_rdata !== e.rdata || rsp_nack !== e.nack || rsp_arb_lost !== e.arb) begin
                    bad++;
                    $display("FAIL rsp_fields got rdata=%h nack=%b arb=%b want rdata=%h nack=%b arb=%b",
                             rsp_rdata, rsp_nack, rsp_arb_lost, e.rdata, e.nack, e.arb);
                end
                if (e.lat != 0) begin
                    total++;
                    if (cyc - e.hs != e.lat) begin
                        bad++;
                        $display("FAIL rsp_latency got %0d want %0d", cyc - e.hs, e.lat);
                    end
                end
            end
        end
    end

    task automatic issue(input logic s, input logic p, input logic r, input logic a, input logic [7:0] wd,
                         input logic [7:0] er, input logic en, input logic ea, input int lat);
        int n;
        @(negedge clk);
        cmd_start = s; cmd_stop = p; cmd_read = r; cmd_ack = a; cmd_wdata = wd; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL handshake got ready=%b want 1", cmd_ready);
        end else begin
            sb.push_back('{er, en, ea, lat, cyc});
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL rsp_timeout got pending=%0d want 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({scl_oe, sda_oe, cmd_ready, rsp_valid, busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got scl_oe,sda_oe,ready,valid,busy=%b want 00000",
                     {scl_oe, sda_oe, cmd_ready, rsp_valid, busy});
        end
        total++;
        if ({rsp_rdata, rsp_nack, rsp_arb_lost} !== 10'b0) begin
            bad++;
            $display("FAIL reset_rsp got rdata=%h nack=%b arb=%b want 0", rsp_rdata, rsp_nack, rsp_arb_lost);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        int s0;
        s0 = stop_cnt; slv_read = 1'b0; slv_ack = 1'b1;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 177);
        wait_rsp();
        total++;
        if (wbyte !== 8'hA5) begin
            bad++;
            $display("FAIL write_bits got %h want a5", wbyte);
        end
        total++;
        if ({scl_oe, sda_oe, busy} !== 3'b000 || stop_cnt != s0 + 1) begin
            bad++;
            $display("FAIL write_idle got scl_oe,sda_oe,busy=%b stops=%0d want 000 stops=%0d",
                     {scl_oe, sda_oe, busy}, stop_cnt - s0, 1);
        end
    endtask

    task automatic test_nack_repeated_start();
        int s0, st0;
        slv_read = 1'b0; slv_ack = 1'b0;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b1, 1'b0, 161);
        wait_rsp();
        repeat (5) @(negedge clk);
        total++;
        if ({busy, scl_oe, sda_oe} !== 3'b110 || wbyte !== 8'h3C) begin
            bad++;
            $display("FAIL hold_after_nack got busy,scl_oe,sda_oe=%b byte=%h want 110 byte=3c",
                     {busy, scl_oe, sda_oe}, wbyte);
        end
        s0 = stop_cnt; st0 = start_cnt;
        slv_read = 1'b1; slv_tx = 8'h5A;
        issue(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h5A, 1'b1, 1'b0, 177);
        wait_rsp();
        total++;
        if (stop_cnt != s0 + 1 || start_cnt != st0 + 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL read_bus got starts=%0d stops=%0d busy=%b want 1 1 0",
                     start_cnt - st0, stop_cnt - s0, busy);
        end
        slv_read = 1'b0; slv_ack = 1'b1;
    endtask

    task automatic test_stretch();
        slv_read = 1'b0; slv_ack = 1'b1; stretch_arm = 1'b1;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 8'h00, 1'b0, 1'b0, 227);
        wait_rsp();
        stretch_arm = 1'b0;
        total++;
        if (wbyte !== 8'hC3 || stretch_done !== 1'b1) begin
            bad++;
            $display("FAIL stretch_data got %h stretched=%b want c3 1", wbyte, stretch_done);
        end
    endtask

    task automatic test_arbitration();
        int n, s0;
        s0 = stop_cnt; arb_arm = 1'b1;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 46);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (rsp_valid !== 1'b1 || {scl_oe, sda_oe} !== 2'b00) begin
            bad++;
            $display("FAIL arb_release got valid=%b scl_oe,sda_oe=%b want 1 00", rsp_valid, {scl_oe, sda_oe});
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || stop_cnt != s0) begin
            bad++;
            $display("FAIL arb_no_stop got busy=%b stops=%0d want 0 0", busy, stop_cnt - s0);
        end
        arb_arm = 1'b0;
        wait_rsp();
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'h77, 8'h00, 1'b0, 1'b0, 177);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({scl_oe, sda_oe, busy, rsp_valid} !== 4'b0000) begin
            bad++;
            $display("FAIL mid_reset got scl_oe,sda_oe,busy,valid=%b want 0000", {scl_oe, sda_oe, busy, rsp_valid});
        end
        rst = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 177);
        wait_rsp();
        total++;
        if (wbyte !== 8'h12 || busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_write got %h busy=%b want 12 0", wbyte, busy);
        end
    endtask

    task automatic test_back_to_back();
        int n, c0;
        c0 = rsp_cnt; slv_read = 1'b0; slv_ack = 1'b1;
        @(negedge clk);
        cmd_start = 1'b1; cmd_stop = 1'b0; cmd_read = 1'b0; cmd_ack = 1'b0; cmd_wdata = 8'h11; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        sb.push_back('{8'h00, 1'b0, 1'b0, 161, cyc});
        @(negedge clk);
        cmd_start = 1'b0; cmd_stop = 1'b1; cmd_wdata = 8'h22;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_in_rsp got valid=%b ready=%b want 1 0", rsp_valid, cmd_ready);
        end
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_rsp got %b want 1", cmd_ready);
        end else begin
            sb.push_back('{8'h00, 1'b0, 1'b0, 161, cyc});
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_rsp();
        repeat (20) @(negedge clk);
        total++;
        if (rsp_cnt - c0 != 2 || wbyte !== 8'h22 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_count got rsps=%0d byte=%h busy=%b want 2 22 0", rsp_cnt - c0, wbyte, busy);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_nack_repeated_start();
        test_stretch();
        test_arbitration();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got running want finished");
        $fatal(1, "watchdog expired");
    end
endmodule
